// File: rtl/lsu_bus_master.sv
// Turns one LSU request into a single AXI4-Lite read or write and returns the result on a valid/ready port.
// Optional bus-wait timeout is compiled in with LSU_BUS_TIMEOUT_EN.
module lsu_bus_master #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  input  logic [3:0]      req_wmask_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            m_awvalid_o,
  input  logic            m_awready_i,
  output logic [XLEN-1:0] m_awaddr_o,
  output logic            m_wvalid_o,
  input  logic            m_wready_i,
  output logic [XLEN-1:0] m_wdata_o,
  output logic [3:0]      m_wstrb_o,
  input  logic            m_bvalid_i,
  output logic            m_bready_o,
  input  logic [1:0]      m_bresp_i,
  output logic            m_arvalid_o,
  input  logic            m_arready_i,
  output logic [XLEN-1:0] m_araddr_o,
  input  logic            m_rvalid_i,
  output logic            m_rready_o,
  input  logic [XLEN-1:0] m_rdata_i,
  input  logic [1:0]      m_rresp_i
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP} state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q, wdata_q, rspRdata_q;
  logic [3:0]      wmask_q;
  logic            arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic            rspValid_q, rspErr_q;
  logic            awDone_q, wDone_q;
  logic            awDone_d, wDone_d;
  logic            timeout;

  // A handshake in the current cycle counts as done, so AW and W may finish together.
  assign awDone_d = awDone_q | (awvalid_q & m_awready_i);
  assign wDone_d  = wDone_q  | (wvalid_q  & m_wready_i);

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rspValid_q;
  assign rsp_rdata_o = rspRdata_q;
  assign rsp_err_o   = rspErr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_awaddr_o  = addr_q;
  assign m_wvalid_o  = wvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wmask_q;
  assign m_bready_o  = bready_q;
  assign m_arvalid_o = arvalid_q;
  assign m_araddr_o  = addr_q;
  assign m_rready_o  = rready_q;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] waitCnt_q;
  logic             waitState, progress;

  assign waitState = (state_q == RD_ADDR) || (state_q == RD_DATA) ||
                     (state_q == WR_REQ)  || (state_q == WR_RESP);
  assign timeout   = waitState && (waitCnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign progress  = ((state_q == RD_ADDR) && m_arready_i) ||
                     ((state_q == RD_DATA) && m_rvalid_i)  ||
                     ((state_q == WR_REQ)  && awDone_d && wDone_d) ||
                     ((state_q == WR_RESP) && m_bvalid_i);

  always_ff @(posedge clk_i) begin
    if (rst_i || progress || timeout || !waitState) waitCnt_q <= '0;
    else                                            waitCnt_q <= waitCnt_q + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      rspValid_q <= 1'b0;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
    end else if (timeout) begin
      // Abandon the bus transaction; any late slave response is ignored.
      state_q    <= RSP;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      awDone_q   <= 1'b0;
      wDone_q    <= 1'b0;
      rspValid_q <= 1'b1;
      rspRdata_q <= '0;
      rspErr_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
            if (req_we_i) begin
              state_q   <= WR_REQ;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= RD_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (m_arready_i) begin
            state_q   <= RD_DATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (m_rvalid_i) begin
            state_q    <= RSP;
            rready_q   <= 1'b0;
            rspValid_q <= 1'b1;
            rspRdata_q <= m_rdata_i;
            rspErr_q   <= (m_rresp_i != 2'b00);
          end
        end
        WR_REQ: begin
          if (m_awready_i) awvalid_q <= 1'b0;
          if (m_wready_i)  wvalid_q  <= 1'b0;
          if (awDone_d && wDone_d) begin
            state_q  <= WR_RESP;
            bready_q <= 1'b1;
            awDone_q <= 1'b0;
            wDone_q  <= 1'b0;
          end else begin
            awDone_q <= awDone_d;
            wDone_q  <= wDone_d;
          end
        end
        WR_RESP: begin
          if (m_bvalid_i) begin
            state_q    <= RSP;
            bready_q   <= 1'b0;
            rspValid_q <= 1'b1;
            rspRdata_q <= '0;
            rspErr_q   <= (m_bresp_i != 2'b00);
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q    <= IDLE;
            rspValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Directed testbench for lsu_bus_master; acts as LSU and AXI4-Lite slave.
// Build with LSU_BUS_TIMEOUT_EN defined to also exercise the timeout path.
module tb_lsu_bus_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        reqValid, reqReady, reqWe;
   logic [31:0] reqAddr, reqWdata;
   logic [3:0]  reqWmask;
   logic        rspValid, rspReady, rspErr;
   logic [31:0] rspRdata;
   logic        awValid, awReady, wValid, wReady, bValid, bReady;
   logic        arValid, arReady, rValid, rReady;
   logic [31:0] awAddr, wData, arAddr, rData;
   logic [3:0]  wStrb;
   logic [1:0]  bResp, rResp;

   int assertCount = 0;
   int failCount   = 0;
   int awHsCount   = 0;
   int wHsCount    = 0;
   int overlapCount = 0;
   int awBase, wBase, overlapBase;

   lsu_bus_master #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
      .clk_i(clock), .rst_i(reset),
      .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
      .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_wmask_i(reqWmask),
      .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr),
      .m_awvalid_o(awValid), .m_awready_i(awReady), .m_awaddr_o(awAddr),
      .m_wvalid_o(wValid), .m_wready_i(wReady), .m_wdata_o(wData), .m_wstrb_o(wStrb),
      .m_bvalid_i(bValid), .m_bready_o(bReady), .m_bresp_i(bResp),
      .m_arvalid_o(arValid), .m_arready_i(arReady), .m_araddr_o(arAddr),
      .m_rvalid_i(rValid), .m_rready_o(rReady), .m_rdata_i(rData), .m_rresp_i(rResp)
   );

   // Free-running clock, 10 time units per period.
   always #5 clock = ~clock;

   // Bus monitor: counts handshakes and any cycle with read and write channels active together.
   always @(posedge clock) begin
      if (awValid && awReady) awHsCount++;
      if (wValid && wReady) wHsCount++;
      if ((arValid || rReady) && (awValid || wValid || bReady)) overlapCount++;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] mask);
      reqValid = 1'b1;
      reqWe    = we;
      reqAddr  = addr;
      reqWdata = wdata;
      reqWmask = mask;
   endtask

   task automatic idleSlave();
      awReady = 1'b0; wReady = 1'b0; bValid = 1'b0; bResp = 2'b00;
      arReady = 1'b0; rValid = 1'b0; rData = 32'h0; rResp = 2'b00;
   endtask

   // Linear directed sequence; every step is one clock, checked #1 after the edge.
   initial begin
      reset = 1'b1;
      reqValid = 1'b0; reqWe = 1'b0; reqAddr = 32'h0; reqWdata = 32'h0; reqWmask = 4'h0;
      rspReady = 1'b0;
      idleSlave();
      tick(); tick();
      reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_arvalid",   32'(arValid),  32'd0);
      checkOutput("rst_awvalid",   32'(awValid),  32'd0);
      checkOutput("rst_wvalid",    32'(wValid),   32'd0);
      checkOutput("rst_bready",    32'(bReady),   32'd0);
      checkOutput("rst_rready",    32'(rReady),   32'd0);
      checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
      checkOutput("rst_rsp_rdata", rspRdata,      32'h0);
      checkOutput("rst_rsp_err",   32'(rspErr),   32'd0);

      $display("[TB] zero-wait load");
      arReady = 1'b1;
      applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'h0);
      tick();
      reqValid = 1'b0;
      checkOutput("ld_c1_arvalid", 32'(arValid), 32'd1);
      checkOutput("ld_c1_araddr",  arAddr,       32'h8000_0010);
      checkOutput("ld_c1_ready",   32'(reqReady), 32'd0);
      tick();
      checkOutput("ld_c2_arvalid", 32'(arValid), 32'd0);
      checkOutput("ld_c2_rready",  32'(rReady),  32'd1);
      checkOutput("ld_c2_rspv",    32'(rspValid), 32'd0);
      rValid = 1'b1; rData = 32'hDEAD_BEEF; rResp = 2'b00;
      tick();
      rValid = 1'b0;
      checkOutput("ld_c3_rspv",  32'(rspValid), 32'd1);
      checkOutput("ld_c3_rdata", rspRdata,      32'hDEAD_BEEF);
      checkOutput("ld_c3_err",   32'(rspErr),   32'd0);
      checkOutput("ld_c3_rready", 32'(rReady),  32'd0);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("ld_done_rspv",  32'(rspValid), 32'd0);
      checkOutput("ld_done_ready", 32'(reqReady), 32'd1);
      idleSlave();

      $display("[TB] store, AW three cycles ahead of W");
      awBase = awHsCount; wBase = wHsCount;
      applyStimulus(1'b1, 32'h8000_0004, 32'h0000_AB00, 4'b0010);
      tick();
      reqValid = 1'b0;
      checkOutput("st_c1_awvalid", 32'(awValid), 32'd1);
      checkOutput("st_c1_wvalid",  32'(wValid),  32'd1);
      checkOutput("st_c1_awaddr",  awAddr,       32'h8000_0004);
      checkOutput("st_c1_wstrb",   32'(wStrb),   32'h2);
      checkOutput("st_c1_wdata",   wData,        32'h0000_AB00);
      awReady = 1'b1;
      tick();
      awReady = 1'b0;
      checkOutput("st_c2_awvalid", 32'(awValid), 32'd0);
      checkOutput("st_c2_wvalid",  32'(wValid),  32'd1);
      tick();
      checkOutput("st_c3_wvalid",  32'(wValid),  32'd1);
      checkOutput("st_c3_bready",  32'(bReady),  32'd0);
      tick();
      wReady = 1'b1;
      tick();
      wReady = 1'b0;
      checkOutput("st_c5_wvalid", 32'(wValid), 32'd0);
      checkOutput("st_c5_bready", 32'(bReady), 32'd1);
      bValid = 1'b1; bResp = 2'b00;
      tick();
      bValid = 1'b0;
      checkOutput("st_rspv",     32'(rspValid), 32'd1);
      checkOutput("st_err",      32'(rspErr),   32'd0);
      checkOutput("st_rdata",    rspRdata,      32'h0);
      checkOutput("st_bready",   32'(bReady),   32'd0);
      checkOutput("st_aw_count", 32'(awHsCount - awBase), 32'd1);
      checkOutput("st_w_count",  32'(wHsCount - wBase),   32'd1);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("st_done_rspv", 32'(rspValid), 32'd0);

      $display("[TB] load with SLVERR and stalled response");
      arReady = 1'b1;
      applyStimulus(1'b0, 32'h8000_0100, 32'h0, 4'h0);
      tick();
      reqValid = 1'b0;
      tick();
      checkOutput("er_c2_rready", 32'(rReady), 32'd1);
      rValid = 1'b1; rData = 32'h1234_5678; rResp = 2'b10;
      tick();
      rValid = 1'b0; rData = 32'h0; rResp = 2'b00;
      for (int i = 0; i < 4; i++) begin
         checkOutput("er_hold_rspv",  32'(rspValid), 32'd1);
         checkOutput("er_hold_err",   32'(rspErr),   32'd1);
         checkOutput("er_hold_rdata", rspRdata,      32'h1234_5678);
         checkOutput("er_hold_ready", 32'(reqReady), 32'd0);
         tick();
      end
      checkOutput("er_still_rspv", 32'(rspValid), 32'd1);
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      checkOutput("er_done_rspv",  32'(rspValid), 32'd0);
      checkOutput("er_done_ready", 32'(reqReady), 32'd1);
      idleSlave();

      $display("[TB] reset during read data phase");
      arReady = 1'b1;
      applyStimulus(1'b0, 32'h8000_0200, 32'h0, 4'h0);
      tick();
      reqValid = 1'b0;
      tick();
      checkOutput("rr_c2_rready", 32'(rReady), 32'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      arReady = 1'b0;
      checkOutput("rr_rready",  32'(rReady),   32'd0);
      checkOutput("rr_ready",   32'(reqReady), 32'd1);
      checkOutput("rr_rspv",    32'(rspValid), 32'd0);
      checkOutput("rr_arvalid", 32'(arValid),  32'd0);
      rValid = 1'b1; rData = 32'h5555_AAAA;
      tick();
      rValid = 1'b0;
      checkOutput("rr_late_rspv",   32'(rspValid), 32'd0);
      checkOutput("rr_late_rready", 32'(rReady),   32'd0);
      tick();
      checkOutput("rr_idle_rspv", 32'(rspValid), 32'd0);
      idleSlave();

`ifdef LSU_BUS_TIMEOUT_EN
      $display("[TB] read address timeout");
      applyStimulus(1'b0, 32'h8000_0300, 32'h0, 4'h0);
      tick();
      reqValid = 1'b0;
      for (int i = 1; i < 8; i++) begin
         checkOutput("to_wait_arvalid", 32'(arValid),  32'd1);
         checkOutput("to_wait_rspv",    32'(rspValid), 32'd0);
         tick();
      end
      checkOutput("to_c8_rspv", 32'(rspValid), 32'd0);
      tick();
      checkOutput("to_rspv",    32'(rspValid), 32'd1);
      checkOutput("to_err",     32'(rspErr),   32'd1);
      checkOutput("to_rdata",   rspRdata,      32'h0);
      checkOutput("to_arvalid", 32'(arValid),  32'd0);
      arReady = 1'b1;
      rspReady = 1'b1;
      tick();
      rspReady = 1'b0;
      arReady = 1'b0;
      checkOutput("to_done_rspv",    32'(rspValid), 32'd0);
      checkOutput("to_done_arvalid", 32'(arValid),  32'd0);
`endif

      $display("[TB] back-to-back store then load");
      overlapBase = overlapCount;
      awReady = 1'b1; wReady = 1'b1; bValid = 1'b1; bResp = 2'b00;
      arReady = 1'b1; rValid = 1'b1; rData = 32'hCAFE_F00D; rResp = 2'b00;
      rspReady = 1'b1;
      applyStimulus(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF);
      tick();
      applyStimulus(1'b0, 32'h8000_0030, 32'h0, 4'h0);
      checkOutput("bb_c1_awvalid", 32'(awValid),  32'd1);
      checkOutput("bb_c1_ready",   32'(reqReady), 32'd0);
      tick();
      checkOutput("bb_c2_bready", 32'(bReady),   32'd1);
      checkOutput("bb_c2_ready",  32'(reqReady), 32'd0);
      tick();
      checkOutput("bb_c3_rspv",  32'(rspValid), 32'd1);
      checkOutput("bb_c3_rdata", rspRdata,      32'h0);
      checkOutput("bb_c3_ready", 32'(reqReady), 32'd0);
      tick();
      checkOutput("bb_c4_rspv",    32'(rspValid), 32'd0);
      checkOutput("bb_c4_ready",   32'(reqReady), 32'd1);
      checkOutput("bb_c4_arvalid", 32'(arValid),  32'd0);
      tick();
      reqValid = 1'b0;
      checkOutput("bb_c5_arvalid", 32'(arValid), 32'd1);
      checkOutput("bb_c5_araddr",  arAddr,       32'h8000_0030);
      checkOutput("bb_c5_awvalid", 32'(awValid), 32'd0);
      tick();
      checkOutput("bb_c6_rready", 32'(rReady), 32'd1);
      tick();
      checkOutput("bb_c7_rspv",  32'(rspValid), 32'd1);
      checkOutput("bb_c7_rdata", rspRdata,      32'hCAFE_F00D);
      checkOutput("bb_c7_err",   32'(rspErr),   32'd0);
      tick();
      rspReady = 1'b0;
      idleSlave();
      checkOutput("bb_c8_rspv",   32'(rspValid), 32'd0);
      checkOutput("bb_no_overlap", 32'(overlapCount - overlapBase), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
